// File: rtl/uart_boot_ctrl_pkg.sv
// uart_boot_ctrl_pkg
//   Shared types and constants for the framed UART program loader.
//   - BOOT_SYNC_BYTE : first byte of every frame
//   - boot_state_t   : loader FSM states
//   - boot_err_t     : error codes reported on err_code
//   - in_frame()     : true for the states between SYNC and the checksum byte
package uart_boot_ctrl_pkg;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CSUM,
    ERR_TIMEOUT
  } boot_err_t;

  function automatic logic in_frame(boot_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/boot_idle_timer.sv
// boot_idle_timer
//   Counts idle clocks while enabled. The count returns to zero whenever
//   clr is high or the timer is disabled. expire is a combinational strobe
//   raised in the cycle whose closing edge brings the count to LIMIT-1, so
//   the owner can change state on that same edge.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   en         : count enable (frame in progress)
//   clr        : restart the count (a byte arrived); also masks expire
//   expire     : idle limit reached this cycle
module boot_idle_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LIMIT - 1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the expiring cycle wins, so clr masks expire.
  assign expire = en && !clr && (cnt_q == CW'(LIMIT - 2));

endmodule

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl
//   Framed program loader between a UART receiver and a byte-wide CPU
//   memory write port. Frame: A5, LEN_LO, LEN_HI, LEN payload bytes, CSUM
//   (8-bit sum of payload). Holds the CPU in reset until a full frame with a
//   good checksum is loaded.
// Handshake: rx_valid is a one-cycle strobe; rx_data is meaningful only while
//   it is high. There is no back-pressure: every strobe is consumed on the
//   edge that samples it. mem_we is a one-cycle strobe qualifying mem_addr and
//   mem_wdata; the memory must accept a write every cycle.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rx_valid, rx_data     : received byte strobe and data
//   mem_we/addr/wdata     : registered memory write port
//   cpu_reset_n           : 1 lets the CPU run (only in RUN)
//   busy                  : frame in progress (LEN_LO..CSUM)
//   err, err_code         : sticky error and its cause, cleared by SYNC
//   dbg_state             : current FSM state
module uart_boot_ctrl
  import uart_boot_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code,
  output boot_state_t           dbg_state
);

  // Length and byte counter need one extra bit to hold 2**ADDR_WIDTH.
  localparam int unsigned LW      = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

  boot_state_t           state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [7:0]            sum_q, sum_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  cpu_reset_n_q, cpu_reset_n_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  boot_err_t             err_code_q, err_code_d;

  logic [15:0]           len_full;
  logic                  tmr_expire;

  // busy_q is exactly "state_q is inside a frame", so it gates the timer.
  boot_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (busy_q),
    .clr    (rx_valid),
    .expire (tmr_expire)
  );

  assign len_full = {rx_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    case (state_q)
      IDLE, RUN, ERROR: begin
        if (rx_valid && (rx_data == BOOT_SYNC_BYTE)) begin
          state_d    = LEN_LO;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          sum_d      = '0;
          cnt_d      = '0;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN)) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            len_d   = LW'(len_full);
            cnt_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
          mem_wdata_d = rx_data;
          sum_d       = sum_q + rx_data;
          cnt_d       = cnt_q + LW'(1);
          if ((cnt_q + LW'(1)) == len_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = RUN;
          end else begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Only fires in frame states with no byte this cycle.
    if (tmr_expire) begin
      state_d    = ERROR;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end

    busy_d        = in_frame(state_d);
    cpu_reset_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      len_lo_q      <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      sum_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      len_lo_q      <= len_lo_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign dbg_state   = state_q;

endmodule
